dump_frame_rx: RTL
==================

DUMP_FRAME_RX -- requirements
Module: dump_frame_rx

Interface
REQ-001 SHALL have parameter GAP_TIMEOUT, default 100000, giving the maximum clk cycles between bytes of one frame (1 ms at 100 MHz).
REQ-002 SHALL have port clk, input, 1, system clock (100 MHz domain).
REQ-003 SHALL have port rst, input, 1, reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port rx_byte, input, 8, received UART byte, valid only when rx_dv=1.
REQ-005 SHALL have port rx_dv, input, 1, one-cycle strobe marking rx_byte valid.
REQ-006 SHALL have port rec_data, output, 32, reconstructed memory record.
REQ-007 SHALL have port rec_type, output, 1, record type: 0 = meter sample, 1 = logic pack.
REQ-008 SHALL have port rec_valid, output, 1, rec_data/rec_type are valid.
REQ-009 SHALL have port rec_ready, input, 1, consumer accepts the record.
REQ-010 SHALL have port cksum_err, output, 1, one-cycle pulse when a frame fails its checksum.
REQ-011 SHALL have port frame_err, output, 1, one-cycle pulse when a frame has a reserved-bit violation or gap timeout.
REQ-012 SHALL have port overflow, output, 1, one-cycle pulse when a good frame is dropped because the output register is full.

Function
REQ-013 SHALL decode 6-byte dump frames: header 0x0A (sample) or 0x0C (logic), then payload bytes P1..P5.
REQ-014 Sample frame SHALL carry P1={0000,V[11:8]}, P2=V[7:0], P3={0000,I[11:8]}, P4=I[7:0], P5={00,CK[5:0]}; record SHALL be {V,I,CK,1'b0,1'b1}.
REQ-015 Logic frame SHALL carry P1=D[15:8], P2=D[7:0], P3=0x00, P4=0x00, P5={00,CK}; record SHALL be {D,8'h00,CK,2'b11}.
REQ-016 Sample checksum SHALL be the low 6 bits of V[11:4] + {V[3:0],I[11:8]} + I[7:0]; logic checksum SHALL be the low 6 bits of D[15:8] + D[7:0].
REQ-017 FSM states SHALL be HUNT, P1, P2, P3, P4, P5, CHECK; each rx_dv advances exactly one byte state.
REQ-018 In HUNT, a byte other than 0x0A/0x0C SHALL be discarded silently with no error pulse.
REQ-019 A nonzero reserved bit (sample P1/P3 upper nibble, any P5[7:6], logic P3/P4) SHALL pulse frame_err in CHECK and return the FSM to HUNT.
REQ-020 If more than GAP_TIMEOUT cycles pass between bytes in states P1..P5, the block SHALL pulse frame_err and return to HUNT.
REQ-021 CHECK SHALL last one cycle: good frame -> rec_valid=1 on the next cycle (2 cycles after the P5 rx_dv); FSM returns to HUNT.
REQ-022 The output register SHALL hold data while rec_valid=1 and rec_ready=0; the transfer occurs on a cycle with rec_valid and rec_ready both 1.
REQ-023 A good frame reaching CHECK while the register is full and not being accepted that same cycle SHALL be dropped with an overflow pulse; the held record is not altered.
REQ-024 A good frame reaching CHECK in the cycle the held record is accepted SHALL load without overflow.
REQ-025 Reception SHALL continue while rec_valid=1; a rx_dv in CHECK SHALL be treated as a HUNT byte.
REQ-026 At most one error pulse SHALL occur per frame, with priority frame_err > cksum_err > overflow.

Reset
REQ-027 While rst=0: FSM=HUNT, gap counter=0, rec_data=0, rec_type=0, rec_valid=0, cksum_err=frame_err=overflow=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first byte after release SHALL be evaluated in HUNT.

Configuration
REQ-029 Macro DUMP_RX_CHECKSUM_EN: when defined, checksum is verified per REQ-016 and mismatches pulse cksum_err and drop the frame.
REQ-030 Without DUMP_RX_CHECKSUM_EN: checksum is not checked, the received CK is passed into rec_data unchanged, and cksum_err is tied to 0.

Structure
REQ-031 Package dump_pkg SHALL hold the header constants 0x0A/0x0C, the rec_type codes, the record width (32), and the checksum width (6), for shared use with the dump transmitter.
REQ-032 The gap counter SHALL be a sub-module dump_gap_timer (restart on rx_dv, enable outside HUNT, expire pulse).

Verification
REQ-033 Bytes 0A 01 23 04 56 1C, rec_ready=1 -> rec_valid one cycle, rec_data=0x12345671, rec_type=0, no error pulses.
REQ-034 Bytes 0C AB CD 00 00 38 -> rec_data=0xABCD00E3, rec_type=1.
REQ-035 Bytes 0A 01 23 04 56 1D -> with DUMP_RX_CHECKSUM_EN: cksum_err pulse, no rec_valid; without it: rec_data=0x12345675.
REQ-036 Bytes 0A 01 23, then idle GAP_TIMEOUT+1 cycles, then 0C AB CD 00 00 38 -> one frame_err, then rec_data=0xABCD00E3.
REQ-037 rec_ready=0, two good frames back-to-back -> first record held, one overflow pulse, rec_data unchanged; raise rec_ready -> one transfer.
REQ-038 rst=0 asserted after byte P2 of a frame, then released, then a full good frame -> only the second frame is output.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared constants, receiver FSM states and checksum helpers for the dump
// frame link (receiver and transmitter).
package dump_pkg;

  localparam logic [7:0] HDR_SAMPLE      = 8'h0A;
  localparam logic [7:0] HDR_LOGIC       = 8'h0C;
  localparam logic       REC_TYPE_SAMPLE = 1'b0;
  localparam logic       REC_TYPE_LOGIC  = 1'b1;
  localparam int         REC_W           = 32;
  localparam int         CK_W            = 6;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_P1    = 3'd1,
    ST_P2    = 3'd2,
    ST_P3    = 3'd3,
    ST_P4    = 3'd4,
    ST_P5    = 3'd5,
    ST_CHECK = 3'd6
  } rx_state_e;

  // Sample checksum sums the 24 bits of V and I as three bytes.
  function automatic logic [CK_W-1:0] sample_cksum(input logic [11:0] v, input logic [11:0] i);
    logic [7:0] sum;
    sum = v[11:4] + {v[3:0], i[11:8]} + i[7:0];
    return sum[CK_W-1:0];
  endfunction

  function automatic logic [CK_W-1:0] logic_cksum(input logic [15:0] d);
    logic [7:0] sum;
    sum = d[15:8] + d[7:0];
    return sum[CK_W-1:0];
  endfunction

endpackage

// File: rtl/dump_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled, restarts on each
// received byte and pulses expire once more than GAP_TIMEOUT cycles have passed.
module dump_gap_timer #(
  parameter int GAP_TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic expire
);

  localparam int CNT_W = (GAP_TIMEOUT < 1) ? 1 : $clog2(GAP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(GAP_TIMEOUT);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (!en || restart) begin
      cnt_reg <= '0;
    end else if (cnt_reg != LIMIT) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // cnt_reg reaches LIMIT on the GAP_TIMEOUT-th idle cycle; one more idle cycle expires.
  assign expire = en && !restart && (cnt_reg == LIMIT);

endmodule

// File: rtl/dump_frame_rx.sv
// Dump frame receiver: decodes 6-byte sample/logic frames into 32-bit records.
// Checksum verification is built only when DUMP_RX_CHECKSUM_EN is defined.
module dump_frame_rx
  import dump_pkg::*;
#(
  parameter int GAP_TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_byte,
  input  logic             rx_dv,
  output logic [REC_W-1:0] rec_data,
  output logic             rec_type,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic             cksum_err,
  output logic             frame_err,
  output logic             overflow
);

  rx_state_e        state_reg, state_next;
  logic             type_reg;
  logic [7:0]       pay_reg [5];
  logic [REC_W-1:0] rec_data_reg;
  logic             rec_type_reg;
  logic             rec_valid_reg;
  logic             cksum_err_reg, frame_err_reg, overflow_reg;

  logic             hdr_hit, load_hdr, load_rec, expire;
  logic             frame_err_next, cksum_err_next, overflow_next;
  logic             rsv_bad, ck_ok;
  logic [11:0]      v_val, i_val;
  logic [15:0]      d_val;
  logic [CK_W-1:0]  ck_rx;
  logic [REC_W-1:0] rec_word;

  assign hdr_hit = rx_dv && ((rx_byte == HDR_SAMPLE) || (rx_byte == HDR_LOGIC));

  dump_gap_timer #(.GAP_TIMEOUT(GAP_TIMEOUT)) u_gap (
    .clk    (clk),
    .rst    (rst),
    .en     (state_reg != ST_HUNT),
    .restart(rx_dv),
    .expire (expire)
  );

  // Payload byte n is captured by the rx_dv seen in state P(n+1).
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_pay
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pay_reg[gi] <= '0;
        end else if (rx_dv && (state_reg == rx_state_e'(3'(gi + 1)))) begin
          pay_reg[gi] <= rx_byte;
        end
      end
    end
  endgenerate

  assign v_val = {pay_reg[0][3:0], pay_reg[1]};
  assign i_val = {pay_reg[2][3:0], pay_reg[3]};
  assign d_val = {pay_reg[0], pay_reg[1]};
  assign ck_rx = pay_reg[4][CK_W-1:0];

  assign rec_word = (type_reg == REC_TYPE_LOGIC) ? {d_val, 8'h00, ck_rx, 2'b11}
                                                 : {v_val, i_val, ck_rx, 1'b0, 1'b1};

  assign rsv_bad = (pay_reg[4][7:6] != 2'b00) ||
                   ((type_reg == REC_TYPE_LOGIC) ? ((pay_reg[2] != 8'h00) || (pay_reg[3] != 8'h00))
                                                 : ((pay_reg[0][7:4] != 4'h0) || (pay_reg[2][7:4] != 4'h0)));

`ifdef DUMP_RX_CHECKSUM_EN
  assign ck_ok = (ck_rx == ((type_reg == REC_TYPE_LOGIC) ? logic_cksum(d_val)
                                                         : sample_cksum(v_val, i_val)));
`else
  assign ck_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_HUNT;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    load_hdr       = 1'b0;
    load_rec       = 1'b0;
    frame_err_next = 1'b0;
    cksum_err_next = 1'b0;
    overflow_next  = 1'b0;
    case (state_reg)
      ST_HUNT: begin
        if (hdr_hit) begin
          state_next = ST_P1;
          load_hdr   = 1'b1;
        end
      end
      ST_P1, ST_P2, ST_P3, ST_P4, ST_P5: begin
        if (expire) begin
          state_next     = ST_HUNT;
          frame_err_next = 1'b1;
        end else if (rx_dv) begin
          case (state_reg)
            ST_P1:   state_next = ST_P2;
            ST_P2:   state_next = ST_P3;
            ST_P3:   state_next = ST_P4;
            ST_P4:   state_next = ST_P5;
            default: state_next = ST_CHECK;
          endcase
        end
      end
      ST_CHECK: begin
        // Error priority: frame > checksum > overflow; a good frame may load
        // into a register that is being emptied in this same cycle.
        if (rsv_bad)                         frame_err_next = 1'b1;
        else if (!ck_ok)                     cksum_err_next = 1'b1;
        else if (rec_valid_reg && !rec_ready) overflow_next = 1'b1;
        else                                 load_rec       = 1'b1;
        state_next = hdr_hit ? ST_P1 : ST_HUNT;
        load_hdr   = hdr_hit;
      end
      default: state_next = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      type_reg      <= REC_TYPE_SAMPLE;
      rec_data_reg  <= '0;
      rec_type_reg  <= REC_TYPE_SAMPLE;
      rec_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      cksum_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      frame_err_reg <= frame_err_next;
      cksum_err_reg <= cksum_err_next;
      overflow_reg  <= overflow_next;
      if (load_hdr) begin
        type_reg <= (rx_byte == HDR_LOGIC) ? REC_TYPE_LOGIC : REC_TYPE_SAMPLE;
      end
      if (load_rec) begin
        rec_data_reg  <= rec_word;
        rec_type_reg  <= type_reg;
        rec_valid_reg <= 1'b1;
      end else if (rec_valid_reg && rec_ready) begin
        rec_valid_reg <= 1'b0;
      end
    end
  end

  assign rec_data  = rec_data_reg;
  assign rec_type  = rec_type_reg;
  assign rec_valid = rec_valid_reg;
  assign cksum_err = cksum_err_reg;
  assign frame_err = frame_err_reg;
  assign overflow  = overflow_reg;

endmodule
